// File: rtl/vram_arbiter.sv
// Text-RAM arbiter: the display scan-out owns fixed prefetch slots, and the CPU
// gets the remaining cycles through a req/ready handshake (IDLE -> ACCESS -> DONE).
module vram_arbiter #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int AW     = 12,
  parameter int DW     = 8,
  parameter int HA_END = 639,
  parameter int VA_END = 479,
  parameter int LINE   = 799,
  parameter int SCREEN = 524
) (
  input  logic          clk_pix,
  input  logic          rst_pix_n,
  input  logic [9:0]    sx,
  input  logic [9:0]    sy,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ready,
  output logic [DW-1:0] cpu_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [DW-1:0] char_code
);

  localparam int CELLS = COLS * ROWS;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state;
  logic          vld_p1;
  logic [9:0]    ns;
  logic          slot_a;
  logic          slot_b;
  logic          disp_slot;
  logic [AW-1:0] slot_addr;
  logic          in_range;
  logic          grant;

  function automatic logic [AW-1:0] cell_addr(input logic [5:0] row, input logic [6:0] col);
    return AW'(int'(row) * COLS + int'(col));
  endfunction

  // Slot A prefetches the next column in-line; slot B prefetches column 0 of the next line.
  always_comb begin
    ns        = (sy == 10'(SCREEN)) ? 10'd0 : sy + 10'd1;
    slot_a    = (sx[2:0] == 3'd0) && (sx <= 10'(8 * (COLS - 2))) && (sx <= 10'(HA_END))
                && (sy <= 10'(VA_END));
    slot_b    = (sx == 10'(LINE - 7)) && (ns <= 10'(VA_END));
    disp_slot = slot_a || slot_b;
    slot_addr = slot_a ? cell_addr(sy[9:4], sx[9:3] + 7'd1) : cell_addr(ns[9:4], 7'd0);
    in_range  = int'(cpu_addr) < CELLS;
    grant     = rst_pix_n && (state == IDLE) && cpu_req && !disp_slot;
  end

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (disp_slot) begin
      ram_addr = slot_addr;
    end else if (grant) begin
      ram_addr  = cpu_addr;
      ram_we    = cpu_we && in_range;
      ram_wdata = cpu_wdata;
    end
  end

  // p1: RAM data for the slot issued last cycle is on ram_rdata; register it as char_code.
  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      state     <= IDLE;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      char_code <= '0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1    <= disp_slot;
      cpu_ready <= 1'b0;
      if (vld_p1) char_code <= ram_rdata;
      case (state)
        IDLE:    if (grant) state <= ACCESS;
        ACCESS: begin
          cpu_rdata <= in_range ? ram_rdata : '0;
          cpu_ready <= 1'b1;
          state     <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: slot table, directed handshake sequences and a
// randomized run against a cycle-level reference of the arbitration rules.
module tb_vram_arbiter;

  logic        clk_pix = 1'b0;
  logic        rst_pix_n;
  logic [9:0]  sx, sy;
  logic        cpu_req, cpu_we;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ready;
  logic [7:0]  cpu_rdata;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata, ram_rdata, char_code;

  logic [7:0]  ram [0:4095];
  logic [7:0]  mm  [0:2399];

  typedef struct { int due; logic [7:0] val; } fetch_t;
  typedef struct { int x; int y; logic [11:0] a; } vec_t;

  fetch_t      fq[$];
  vec_t        tbl[10];
  logic [7:0]  exp_char;
  int          g_cyc;
  logic        g_we;
  logic [7:0]  g_rd;
  bit          done_flag;
  logic [7:0]  last_rd;
  logic [11:0] s_addr, f_addr;
  logic        s_we, f_we, s_ready;
  logic [7:0]  s_char, s_rdata;
  int          ready_x;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  always #5 clk_pix = ~clk_pix;

  vram_arbiter dut (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .sx(sx), .sy(sy),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .char_code(char_code)
  );

  always @(posedge clk_pix) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d sx=%0d sy=%0d)", nm, act, exp, cyc, sx, sy);
    end
  endtask

  function automatic bit slot_of(input int x, input int y, output int a);
    int n;
    a = 0;
    if (x % 8 == 0 && x <= 8 * 78 && y <= 479) begin
      a = (y / 16) * 80 + x / 8 + 1;
      return 1'b1;
    end
    if (x == 792) begin
      n = (y == 524) ? 0 : y + 1;
      if (n <= 479) begin
        a = (n / 16) * 80;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // One clock: sample at the falling edge, check against the reference, then advance the beam.
  task automatic cycle();
    int a;
    bit sl, inr;
    fetch_t e;
    @(negedge clk_pix);
    s_addr = ram_addr; s_we = ram_we; s_ready = cpu_ready; s_char = char_code; s_rdata = cpu_rdata;
    if (!rst_pix_n) begin
      fq.delete();
      exp_char = 8'h00;
      g_cyc = -1;
    end else begin
      while (fq.size() > 0 && fq[0].due <= cyc) begin
        exp_char = fq[0].val;
        void'(fq.pop_front());
      end
      chk("char_code", char_code, exp_char);
      sl = slot_of(int'(sx), int'(sy), a);
      if (sl) begin
        chk("slot_addr", ram_addr, a);
        chk("slot_we", ram_we, 0);
        e.due = cyc + 2; e.val = mm[a];
        fq.push_back(e);
      end else if (g_cyc < 0 && cpu_req) begin
        inr = cpu_addr < 12'd2400;
        chk("grant_addr", ram_addr, cpu_addr);
        chk("grant_we", ram_we, cpu_we && inr);
        g_rd = inr ? mm[cpu_addr] : 8'h00;
        if (cpu_we && inr) begin
          chk("grant_wdata", ram_wdata, cpu_wdata);
          mm[cpu_addr] = cpu_wdata;
        end
        g_cyc = cyc; g_we = cpu_we;
      end else begin
        chk("idle_addr", ram_addr, 0);
        chk("idle_we", ram_we, 0);
      end
      if (g_cyc >= 0 && cyc == g_cyc + 2) begin
        chk("cpu_ready", cpu_ready, 1);
        if (!g_we) chk("cpu_rdata", cpu_rdata, g_rd);
        ready_x = int'(sx); last_rd = cpu_rdata; done_flag = 1'b1; g_cyc = -1;
      end else begin
        chk("cpu_ready_low", cpu_ready, 0);
      end
    end
    @(posedge clk_pix); #1;
    cyc++;
    if (sx == 10'd799) begin
      sx = 10'd0;
      sy = (sy == 10'd524) ? 10'd0 : sy + 10'd1;
    end else begin
      sx = sx + 10'd1;
    end
  endtask

  task automatic cpu_access(input logic we, input logic [11:0] addr, input logic [7:0] wd, output int lat);
    int c0;
    c0 = cyc;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; done_flag = 1'b0;
    for (int i = 0; i < 10 && !done_flag; i++) begin
      cycle();
      if (i == 0) begin f_addr = s_addr; f_we = s_we; end
    end
    if (done_flag) begin
      lat = cyc - 1 - c0;
    end else begin
      lat = -1;
      total++; bad++;
      $display("FAIL cpu_timeout: no cpu_ready within 10 cycles for addr 0x%0h", addr);
    end
    cpu_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, x, y;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    for (int i = 0; i < 2400; i++) mm[i] = 8'h00;
    exp_char = 8'h00; g_cyc = -1; done_flag = 1'b0;
    rst_pix_n = 1'b0; sx = 10'd100; sy = 10'd500;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    @(posedge clk_pix); #1;
    cycle(); cycle();
    rst_pix_n = 1'b1;
    cycle();
    chk("reset_ready", s_ready, 0);
    chk("reset_char", s_char, 0);
    chk("reset_rdata", s_rdata, 0);
    chk("reset_we", s_we, 0);

    tbl = '{'{0, 0, 12'd1}, '{8, 0, 12'd2}, '{1, 0, 12'd0}, '{624, 0, 12'd79}, '{632, 0, 12'd0},
            '{792, 15, 12'd80}, '{792, 479, 12'd0}, '{792, 524, 12'd0}, '{8, 480, 12'd0},
            '{624, 479, 12'd2399}};
    for (int i = 0; i < 10; i++) begin
      sx = 10'(tbl[i].x); sy = 10'(tbl[i].y); cpu_req = 1'b0;
      cycle();
      chk("tbl_addr", s_addr, tbl[i].a);
      chk("tbl_we", s_we, 0);
    end

    sx = 10'd1; sy = 10'd0;
    cpu_access(1'b1, 12'd5, 8'h41, lat);
    chk("wr_addr", f_addr, 5); chk("wr_we", f_we, 1); chk("wr_lat", lat, 2); chk("wr_ready_x", ready_x, 3);
    sx = 10'd20; sy = 10'd0;
    cpu_access(1'b0, 12'd5, 8'h00, lat);
    chk("rd_lat", lat, 2); chk("rd_data", last_rd, 8'h41);

    sx = 10'd8; sy = 10'd0;
    cpu_access(1'b0, 12'd5, 8'h00, lat);
    chk("col_addr", f_addr, 2); chk("col_we", f_we, 0); chk("col_lat", lat, 3);
    chk("col_ready_x", ready_x, 11); chk("col_data", last_rd, 8'h41);

    sx = 10'd792; sy = 10'd479;
    cpu_access(1'b0, 12'd5, 8'h00, lat);
    chk("noslot_addr", f_addr, 5); chk("noslot_lat", lat, 2);

    sx = 10'd300; sy = 10'd490;
    cpu_access(1'b1, 12'd2400, 8'h77, lat);
    chk("oor_we", f_we, 0); chk("oor_wlat", lat, 2);
    cpu_access(1'b0, 12'd2400, 8'h00, lat);
    chk("oor_rdata", last_rd, 0);
    cpu_access(1'b1, 12'd2399, 8'h11, lat);
    cpu_access(1'b0, 12'd2399, 8'h00, lat);
    chk("edge_rdata", last_rd, 8'h11);

    cpu_access(1'b1, 12'd1, 8'h5A, lat);
    cpu_access(1'b1, 12'd2, 8'h33, lat);
    sx = 10'd790; sy = 10'd524;
    for (int i = 0; i < 23; i++) begin
      x = int'(sx); y = int'(sy);
      cycle();
      if (y == 0 && x >= 2 && x <= 9) chk("scan_col1", s_char, 8'h5A);
      if (y == 0 && x >= 10 && x <= 12) chk("scan_col2", s_char, 8'h33);
    end

    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'd7; cpu_wdata = 8'h99;
    cycle();
    rst_pix_n = 1'b0;
    cycle();
    chk("rst_mid_ready", s_ready, 0); chk("rst_mid_we", s_we, 0);
    cycle();
    chk("rst_mid_ready2", s_ready, 0); chk("rst_mid_we2", s_we, 0);
    cpu_req = 1'b0; rst_pix_n = 1'b1;
    cycle();
    chk("rst_mid_char", s_char, 0); chk("rst_mid_rdata", s_rdata, 0);
    cycle(); cycle();
    cpu_access(1'b0, 12'd7, 8'h00, lat);
    chk("rst_after_lat", lat, 2); chk("rst_after_data", last_rd, 8'h99);

    for (int t = 0; t < 200; t++) begin
      logic [11:0] a;
      int sel;
      if ($urandom_range(0, 7) == 0) begin
        sx = 10'($urandom_range(0, 799)); sy = 10'($urandom_range(0, 524));
      end
      repeat ($urandom_range(0, 4)) cycle();
      sel = $urandom_range(0, 7);
      if (sel < 4) a = 12'($urandom_range(0, 31));
      else if (sel < 7) a = 12'($urandom_range(0, 2399));
      else a = 12'($urandom_range(2400, 4095));
      cpu_access(1'($urandom_range(0, 1)), a, 8'($urandom), lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
